sdrc_req_queue: RTL

Application-side request queue that sits directly upstream of the SDRAM request generator. It accepts application transfer requests and assigns each a free transfer ID from a pool. Requests are buffered in a small FIFO and presented to the request generator on its `req`/`req_ack` handshake. An ID returns to the pool when the transfer controller reports completion for it.

---
 rtl/sdrc_req_queue_pkg.sv | 44 ++++
 rtl/sdrc_req_queue_if.sv | 67 ++++++
 rtl/sdrc_id_pool.sv | 75 +++++++
 rtl/sdrc_req_queue.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sdrc_req_queue_pkg.sv
// ============================================================================
// Module      : sdrc_req_queue_pkg
// Description : Shared types, constants and helper function for the SDRAM
//               application request queue and its transfer-ID pool.
//               Provides defaults for `SDR_REQ_ID_W (ID width) and
//               `SDRC_REQ_Q_DEPTH (FIFO depth) when sdrc_define.v has not
//               already set them.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SDR_REQ_ID_W
`define SDR_REQ_ID_W 4
`endif

`ifndef SDRC_REQ_Q_DEPTH
`define SDRC_REQ_Q_DEPTH 4
`endif

package sdrc_req_queue_pkg;

    localparam int ID_W = `SDR_REQ_ID_W;
    localparam int NID  = 1 << ID_W;

    typedef logic [ID_W-1:0] id_t;
    typedef logic [NID-1:0]  id_vec_t;

    // Index of the lowest set bit; returns 0 for an all-zero vector, so
    // callers must qualify the result with a separate "any set" flag.
    function automatic id_t lowest_set(input id_vec_t v);
        id_t r;
        r = '0;
        for (int i = NID - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = id_t'(i);
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdrc_req_queue_if.sv
// ============================================================================
// Module      : sdrc_req_queue_if
// Description : Bundle of the application request, request-generator
//               handshake, completion and status signals of sdrc_req_queue.
// Modports    : master - application / request-generator / transfer-control
//                        side (drives app_req*, req_ack, xfr_done*)
//               slave  - the request queue itself
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdrc_req_queue_if #(
    parameter int APP_AW = 26,
    parameter int APP_RW = 9,
    parameter int DEPTH  = 4
);
    import sdrc_req_queue_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // application request
    logic              app_req;
    logic [APP_AW-1:0] app_req_addr;
    logic [APP_RW-1:0] app_req_len;
    logic              app_req_wr_n;
    logic              app_req_wrap;
    logic              app_req_ack;
    id_t               app_req_tag;
    // head of queue to the request generator
    logic              req;
    id_t               req_id;
    logic [APP_AW-1:0] req_addr;
    logic [APP_RW-1:0] req_len;
    logic              req_wr_n;
    logic              req_wrap;
    logic              req_ack;
    // transfer completion
    logic              xfr_done;
    id_t               xfr_done_id;
    // status
    logic [CNT_W-1:0]  q_count;
    logic              q_full;
    logic              q_empty;
    logic [ID_W:0]     ids_free;
    logic              err_dbl_free;

    modport master (
        output app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_wrap,
        input  app_req_ack, app_req_tag,
        input  req, req_id, req_addr, req_len, req_wr_n, req_wrap,
        output req_ack,
        output xfr_done, xfr_done_id,
        input  q_count, q_full, q_empty, ids_free, err_dbl_free
    );

    modport slave (
        input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_wrap,
        output app_req_ack, app_req_tag,
        output req, req_id, req_addr, req_len, req_wr_n, req_wrap,
        input  req_ack,
        input  xfr_done, xfr_done_id,
        output q_count, q_full, q_empty, ids_free, err_dbl_free
    );

endinterface

`default_nettype wire

// File: rtl/sdrc_id_pool.sv
// ============================================================================
// Module      : sdrc_id_pool
// Description : Transfer-ID free pool. Holds an NID-bit free vector, offers
//               the lowest-numbered free ID, tracks the free count and flags
//               releases of IDs that are already free (sticky).
// Ports       : clk, reset_n        - clock, async active-low reset
//               alloc_i             - take alloc_id_o out of the pool
//               release_i           - return release_id_i to the pool
//               alloc_id_o          - lowest free ID (valid if free_any_o)
//               free_any_o          - at least one ID is free
//               ids_free_o          - number of free IDs
//               err_dbl_free_o      - sticky double-release flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdrc_id_pool
    import sdrc_req_queue_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    reset_n,
    input  wire logic    alloc_i,
    input  wire logic    release_i,
    input  wire id_t     release_id_i,
    output id_t          alloc_id_o,
    output logic         free_any_o,
    output logic [ID_W:0] ids_free_o,
    output logic         err_dbl_free_o
);
    localparam int CW = ID_W + 1;

    id_vec_t         free_q, free_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            w_rel_ok;
    logic            w_rel_dbl;

    assign alloc_id_o = lowest_set(free_q);
    assign free_any_o = |free_q;

    // A release is judged against the registered vector, so an ID being
    // allocated this cycle counts as free and releasing it is a double free.
    assign w_rel_ok  = release_i & ~free_q[release_id_i];
    assign w_rel_dbl = release_i &  free_q[release_id_i];

    always_comb begin
        free_d = free_q;
        if (alloc_i) begin
            free_d[alloc_id_o] = 1'b0;
        end
        if (w_rel_ok) begin
            free_d[release_id_i] = 1'b1;
        end
        cnt_d = cnt_q + CW'(w_rel_ok) - CW'(alloc_i);
        err_d = err_q | w_rel_dbl;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            free_q <= '1;
            cnt_q  <= CW'(NID);
            err_q  <= 1'b0;
        end else begin
            free_q <= free_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign ids_free_o     = cnt_q;
    assign err_dbl_free_o = err_q;

endmodule

`default_nettype wire

// File: rtl/sdrc_req_queue.sv
// ============================================================================
// Module      : sdrc_req_queue
// Description : Application request queue ahead of the SDRAM request
//               generator. Tags each accepted request with a free transfer
//               ID, buffers it in a DEPTH-entry FIFO and presents the head
//               on the req/req_ack handshake. IDs return on xfr_done.
// Ports       : clk      - clock
//               reset_n  - async active-low reset
//               bus      - sdrc_req_queue_if.slave (request, head, completion
//                          and status signals)
// Config      : SDRC_REQ_ZERO_LEN_DROP_EN - when defined, zero-length requests
//               are acknowledged with tag 0 and dropped (no ID, no FIFO slot).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdrc_req_queue
    import sdrc_req_queue_pkg::*;
#(
    parameter int APP_AW = 26,
    parameter int APP_RW = 9,
    parameter int DEPTH  = `SDRC_REQ_Q_DEPTH
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    sdrc_req_queue_if.slave bus
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    // FIFO storage
    logic [APP_AW-1:0] addr_q [DEPTH];
    logic [APP_RW-1:0] len_q  [DEPTH];
    logic              wr_n_q [DEPTH];
    logic              wrap_q [DEPTH];
    id_t               id_q   [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              w_full;
    logic              w_empty;
    logic              w_zero_drop;
    logic              w_ack;
    logic              w_push;
    logic              w_pop;
    id_t               w_alloc_id;
    logic              w_free_any;

`ifdef SDRC_REQ_ZERO_LEN_DROP_EN
    assign w_zero_drop = (bus.app_req_len == '0);
`else
    assign w_zero_drop = 1'b0;
`endif

    assign w_full  = (count_q == CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);

    // Acceptance uses only registered state: a pop in the same cycle does
    // not open a slot for a push at full.
    assign w_ack  = bus.app_req & (w_zero_drop | (~w_full & w_free_any));
    assign w_push = w_ack & ~w_zero_drop;
    assign w_pop  = bus.req_ack & ~w_empty;

    sdrc_id_pool u_id_pool (
        .clk            (clk),
        .reset_n        (reset_n),
        .alloc_i        (w_push),
        .release_i      (bus.xfr_done),
        .release_id_i   (bus.xfr_done_id),
        .alloc_id_o     (w_alloc_id),
        .free_any_o     (w_free_any),
        .ids_free_o     (bus.ids_free),
        .err_dbl_free_o (bus.err_dbl_free)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(w_push);
        rd_ptr_d = rd_ptr_q + PW'(w_pop);
        count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is reset so the head fields read zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                len_q[i]  <= '0;
                wr_n_q[i] <= 1'b0;
                wrap_q[i] <= 1'b0;
                id_q[i]   <= '0;
            end
        end else if (w_push) begin
            addr_q[wr_ptr_q] <= bus.app_req_addr;
            len_q[wr_ptr_q]  <= bus.app_req_len;
            wr_n_q[wr_ptr_q] <= bus.app_req_wr_n;
            wrap_q[wr_ptr_q] <= bus.app_req_wrap;
            id_q[wr_ptr_q]   <= w_alloc_id;
        end
    end

    assign bus.app_req_ack = w_ack;
    assign bus.app_req_tag = w_zero_drop ? '0 : w_alloc_id;

    assign bus.req      = ~w_empty;
    assign bus.req_id   = id_q[rd_ptr_q];
    assign bus.req_addr = addr_q[rd_ptr_q];
    assign bus.req_len  = len_q[rd_ptr_q];
    assign bus.req_wr_n = wr_n_q[rd_ptr_q];
    assign bus.req_wrap = wrap_q[rd_ptr_q];

    assign bus.q_count = count_q;
    assign bus.q_full  = w_full;
    assign bus.q_empty = w_empty;

endmodule

`default_nettype wire
